// File: rtl/axil_router_wr.sv
// AXI-Lite write-channel router: forwards one AW+W beat to the decoder-selected
// slave and returns its B response, or answers DECERR locally on a decode miss.
module axil_router_wr #(
    parameter int NUMBER_SLAVE   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,

    input  logic [NUMBER_SLAVE-1:0]                     slv_valid,
    input  logic                                        slv_invalid,

    input  logic [AXI_ADDR_WIDTH-1:0]                   m_axil_awaddr,
    input  logic [2:0]                                  m_axil_awprot,
    input  logic                                        m_axil_awvalid,
    output logic                                        m_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]                   m_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]                 m_axil_wstrb,
    input  logic                                        m_axil_wvalid,
    output logic                                        m_axil_wready,
    output logic [1:0]                                  m_axil_bresp,
    output logic                                        m_axil_bvalid,
    input  logic                                        m_axil_bready,

    output logic [NUMBER_SLAVE*AXI_ADDR_WIDTH-1:0]      s_axil_awaddr,
    output logic [NUMBER_SLAVE*3-1:0]                   s_axil_awprot,
    output logic [NUMBER_SLAVE-1:0]                     s_axil_awvalid,
    input  logic [NUMBER_SLAVE-1:0]                     s_axil_awready,
    output logic [NUMBER_SLAVE*AXI_DATA_WIDTH-1:0]      s_axil_wdata,
    output logic [NUMBER_SLAVE*(AXI_DATA_WIDTH/8)-1:0]  s_axil_wstrb,
    output logic [NUMBER_SLAVE-1:0]                     s_axil_wvalid,
    input  logic [NUMBER_SLAVE-1:0]                     s_axil_wready,
    input  logic [NUMBER_SLAVE*2-1:0]                   s_axil_bresp,
    input  logic [NUMBER_SLAVE-1:0]                     s_axil_bvalid,
    output logic [NUMBER_SLAVE-1:0]                     s_axil_bready
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        FWD,
        RESP,
        ERR_ACK,
        ERR_RESP
    } state_t;

    state_t                  r_state;
    logic [NUMBER_SLAVE-1:0] r_sel;
    logic                    r_aw_done;
    logic                    r_w_done;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic [1:0]              w_sel_bresp;

    assign s_axil_awaddr = {NUMBER_SLAVE{m_axil_awaddr}};
    assign s_axil_awprot = {NUMBER_SLAVE{m_axil_awprot}};
    assign s_axil_wdata  = {NUMBER_SLAVE{m_axil_wdata}};
    assign s_axil_wstrb  = {NUMBER_SLAVE{m_axil_wstrb}};

    // Completion is taken from the slave-side handshake so a slave that has
    // accepted a beat is never offered it a second time.
    assign w_aw_hs = |(r_sel & s_axil_awvalid & s_axil_awready);
    assign w_w_hs  = |(r_sel & s_axil_wvalid & s_axil_wready);

    always_comb begin
        w_sel_bresp = '0;
        for (int unsigned k = 0; k < NUMBER_SLAVE; k++) begin
            if (r_sel[k]) begin
                w_sel_bresp = w_sel_bresp | s_axil_bresp[2*k +: 2];
            end
        end
    end

    always_comb begin
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        m_axil_bvalid  = 1'b0;
        m_axil_bresp   = 2'b00;
        s_axil_awvalid = '0;
        s_axil_wvalid  = '0;
        s_axil_bready  = '0;
        case (r_state)
            FWD: begin
                s_axil_awvalid = r_aw_done ? '0 : r_sel;
                s_axil_wvalid  = r_w_done  ? '0 : r_sel;
                m_axil_awready = |(r_sel & s_axil_awready) && !r_aw_done;
                m_axil_wready  = |(r_sel & s_axil_wready)  && !r_w_done;
            end
            RESP: begin
                m_axil_bvalid = |(r_sel & s_axil_bvalid);
                m_axil_bresp  = w_sel_bresp;
                s_axil_bready = m_axil_bready ? r_sel : '0;
            end
            ERR_ACK: begin
                m_axil_awready = 1'b1;
                m_axil_wready  = 1'b1;
            end
            ERR_RESP: begin
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = 2'b11;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_axil_awvalid && m_axil_wvalid) begin
                        r_state <= DECODE;
                    end
                end
                DECODE: begin
                    r_sel <= slv_valid;
                    if (|slv_valid) begin
                        r_state <= FWD;
                    end else if (slv_invalid) begin
                        r_state <= ERR_ACK;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FWD: begin
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_state   <= RESP;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_done <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (m_axil_bvalid && m_axil_bready) begin
                        r_state <= IDLE;
                    end
                end
                ERR_ACK: begin
                    r_state <= ERR_RESP;
                end
                ERR_RESP: begin
                    if (m_axil_bready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_router_wr.sv
// Bench for axil_router_wr: decoder and slave models, directed vector table,
// hand-written reset/start corner cases and randomized writes vs a timing model.
`timescale 1ns/1ps
module tb_axil_router_wr;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW/8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [N-1:0]    slv_valid;
    logic            slv_invalid;
    logic [AW-1:0]   m_awaddr;
    logic [2:0]      m_awprot;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;
    logic [N*AW-1:0] s_awaddr;
    logic [N*3-1:0]  s_awprot;
    logic [N-1:0]    s_awvalid, s_awready;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [N-1:0]    s_wvalid, s_wready;
    logic [N*2-1:0]  s_bresp;
    logic [N-1:0]    s_bvalid, s_bready;

    axil_router_wr #(.NUMBER_SLAVE(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .slv_valid(slv_valid), .slv_invalid(slv_invalid),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
        .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
        .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
        .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
        .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
        .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot),
        .s_axil_awvalid(s_awvalid), .s_axil_awready(s_awready),
        .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
        .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready),
        .s_axil_bresp(s_bresp), .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready)
    );

    int total = 0;
    int bad   = 0;

    // Target of the current write: 0..N-1 mapped, N = unmapped.
    int         cfg_tgt = N;
    int         cfg_aw_lat, cfg_w_lat, cfg_b_lat;
    logic [1:0] cfg_bresp;

    int aw_wait, w_wait, b_wait;
    bit aw_seen, w_seen, b_done;
    int aw_cnt[N], w_cnt[N], exp_aw_cnt[N], exp_w_cnt[N];
    int stray = 0, bcast_err = 0;
    logic [AW-1:0] cap_addr;
    logic [2:0]    cap_prot;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] cap_strb;

    typedef struct {
        int aw_cyc; int w_cyc; int b_cyc;
        logic [1:0] br;
        int aw_rdy_n; int w_rdy_n; int hold_err;
        bit timeout;
    } res_t;

    typedef struct {
        int tgt; int aw_lat; int w_lat; int b_lat; int rdy_lat;
        logic [1:0] br;
        int e_aw; int e_w; int e_b;
        logic [1:0] e_br;
    } vec_t;

    function automatic logic [N-1:0] onehot(input int t);
        onehot = '0;
        if (t >= 0 && t < N) onehot[t] = 1'b1;
    endfunction

    // Address decoder model: registered one cycle after both valids.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            slv_valid   <= '0;
            slv_invalid <= 1'b0;
        end else if (m_awvalid && m_wvalid) begin
            slv_valid   <= onehot(cfg_tgt);
            slv_invalid <= (cfg_tgt >= N);
        end else begin
            slv_valid   <= '0;
            slv_invalid <= 1'b0;
        end
    end

    // Slave models: the target follows its latency config, the rest emit noise.
    always @(negedge aclk) begin
        for (int k = 0; k < N; k++) begin
            if (k == cfg_tgt) begin
                s_awready[k] = s_awvalid[k] && (aw_wait >= cfg_aw_lat);
                if (s_awvalid[k]) aw_wait++;
                s_wready[k] = s_wvalid[k] && (w_wait >= cfg_w_lat);
                if (s_wvalid[k]) w_wait++;
                if (aw_seen && w_seen && !b_done) begin
                    if (b_wait >= cfg_b_lat) s_bvalid[k] = 1'b1;
                    else begin
                        s_bvalid[k] = 1'b0;
                        b_wait++;
                    end
                end else begin
                    s_bvalid[k] = 1'b0;
                end
                s_bresp[2*k +: 2] = cfg_bresp;
            end else begin
                s_awready[k]      = 1'($urandom_range(0, 1));
                s_wready[k]       = 1'($urandom_range(0, 1));
                s_bvalid[k]       = 1'($urandom_range(0, 1));
                s_bresp[2*k +: 2] = 2'($urandom_range(0, 3));
            end
        end
    end

    // Monitor, sampled late in each cycle.
    always @(negedge aclk) begin
        #2;
        for (int k = 0; k < N; k++) begin
            if (s_awaddr[k*AW +: AW] != m_awaddr || s_awprot[k*3 +: 3] != m_awprot ||
                s_wdata[k*DW +: DW] != m_wdata || s_wstrb[k*SW +: SW] != m_wstrb)
                bcast_err++;
            if (s_awvalid[k] && k != cfg_tgt) stray++;
            if (s_wvalid[k] && k != cfg_tgt) stray++;
            if (s_bready[k] && (k != cfg_tgt || !m_bready)) stray++;
            if (s_awvalid[k] && s_awready[k]) begin
                aw_cnt[k]++;
                cap_addr = s_awaddr[k*AW +: AW];
                cap_prot = s_awprot[k*3 +: 3];
                if (k == cfg_tgt) aw_seen = 1'b1;
            end
            if (s_wvalid[k] && s_wready[k]) begin
                w_cnt[k]++;
                cap_data = s_wdata[k*DW +: DW];
                cap_strb = s_wstrb[k*SW +: SW];
                if (k == cfg_tgt) w_seen = 1'b1;
            end
            if (s_bvalid[k] && s_bready[k] && k == cfg_tgt) b_done = 1'b1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int tgt, input int awl, input int wl, input int bl, input logic [1:0] br);
        cfg_tgt = tgt; cfg_aw_lat = awl; cfg_w_lat = wl; cfg_b_lat = bl; cfg_bresp = br;
        aw_wait = 0; w_wait = 0; b_wait = 0;
        aw_seen = 1'b0; w_seen = 1'b0; b_done = 1'b0;
    endtask

    // Master side of one write; cycle 1 is the cycle both valids are first offered.
    task automatic do_write(input int tgt, input int awl, input int wl, input int bl, input int rdyl,
                            input logic [1:0] br, input logic [AW-1:0] a, input logic [2:0] p,
                            input logic [DW-1:0] d, input logic [SW-1:0] s, output res_t r);
        bit aw_d, w_d;
        int bv_first, bv_cnt;
        logic [1:0] br0;
        #1;
        set_cfg(tgt, awl, wl, bl, br);
        r = '{default: 0};
        r.timeout = 1'b1;
        aw_d = 0; w_d = 0; bv_first = 0; bv_cnt = 0; br0 = 2'b00;
        for (int c = 1; c <= 100; c++) begin
            @(negedge aclk);
            if (c == 1) begin
                m_awaddr = a; m_awprot = p; m_wdata = d; m_wstrb = s;
            end
            m_awvalid = !aw_d;
            m_wvalid  = !w_d;
            m_bready  = (bv_cnt >= rdyl);
            #2;
            if (m_awready) r.aw_rdy_n++;
            if (m_wready)  r.w_rdy_n++;
            if (m_awvalid && m_awready) begin aw_d = 1; r.aw_cyc = c; end
            if (m_wvalid && m_wready)   begin w_d = 1;  r.w_cyc = c;  end
            if (m_bvalid) begin
                if (bv_first == 0) begin bv_first = c; br0 = m_bresp; end
                else if (m_bresp != br0) r.hold_err++;
                bv_cnt++;
            end else if (bv_first != 0) begin
                r.hold_err++;
            end
            if (m_bvalid && m_bready) begin
                r.b_cyc = c; r.br = m_bresp; r.timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic judge(input string tag, input int tgt, input int e_aw, input int e_w, input int e_b,
                         input logic [1:0] e_br, input res_t r, input logic [AW-1:0] a,
                         input logic [2:0] p, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (r.timeout) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no B handshake within 100 cycles, expected one", tag);
            return;
        end
        chk({tag, "_awcyc"}, r.aw_cyc, e_aw);
        chk({tag, "_wcyc"},  r.w_cyc,  e_w);
        chk({tag, "_bcyc"},  r.b_cyc,  e_b);
        chk({tag, "_bresp"}, r.br,     e_br);
        chk({tag, "_awrdy_n"}, r.aw_rdy_n, 1);
        chk({tag, "_wrdy_n"},  r.w_rdy_n,  1);
        chk({tag, "_bhold"}, r.hold_err, 0);
        chk({tag, "_stray"}, stray, 0);
        chk({tag, "_bcast"}, bcast_err, 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_awcnt%0d", tag, k), aw_cnt[k], exp_aw_cnt[k]);
            chk($sformatf("%s_wcnt%0d", tag, k),  w_cnt[k],  exp_w_cnt[k]);
        end
        if (tgt < N) begin
            chk({tag, "_addr"}, cap_addr, a);
            chk({tag, "_prot"}, cap_prot, p);
            chk({tag, "_data"}, cap_data, d);
            chk({tag, "_strb"}, cap_strb, s);
        end
    endtask

    // Reference timing: 2 cycles (IDLE, DECODE) before slaves see valid; B one
    // cycle after the later of AW/W plus slave and master delays.
    task automatic model(input int tgt, input int awl, input int wl, input int bl, input int rdyl,
                         input logic [1:0] br, output int e_aw, output int e_w, output int e_b,
                         output logic [1:0] e_br);
        if (tgt < N) begin
            e_aw = 3 + awl;
            e_w  = 3 + wl;
            e_b  = ((e_aw > e_w) ? e_aw : e_w) + 1 + bl + rdyl;
            e_br = br;
            exp_aw_cnt[tgt]++;
            exp_w_cnt[tgt]++;
        end else begin
            e_aw = 3; e_w = 3; e_b = 4 + rdyl; e_br = 2'b11;
        end
    endtask

    vec_t vt[7];
    res_t r;

    initial begin
        int hits;
        int e_aw, e_w, e_b;
        logic [1:0] e_br;
        logic [AW-1:0] a;
        logic [2:0] p;
        logic [DW-1:0] d;
        logic [SW-1:0] s;

        vt[0] = '{tgt: 1, aw_lat: 0, w_lat: 0, b_lat: 2, rdy_lat: 0, br: 2'b00, e_aw: 3, e_w: 3, e_b: 6, e_br: 2'b00};
        vt[1] = '{tgt: 4, aw_lat: 0, w_lat: 0, b_lat: 0, rdy_lat: 0, br: 2'b00, e_aw: 3, e_w: 3, e_b: 4, e_br: 2'b11};
        vt[2] = '{tgt: 2, aw_lat: 3, w_lat: 0, b_lat: 0, rdy_lat: 0, br: 2'b01, e_aw: 6, e_w: 3, e_b: 7, e_br: 2'b01};
        vt[3] = '{tgt: 0, aw_lat: 0, w_lat: 0, b_lat: 0, rdy_lat: 5, br: 2'b10, e_aw: 3, e_w: 3, e_b: 9, e_br: 2'b10};
        vt[4] = '{tgt: 3, aw_lat: 1, w_lat: 0, b_lat: 1, rdy_lat: 0, br: 2'b00, e_aw: 4, e_w: 3, e_b: 6, e_br: 2'b00};
        vt[5] = '{tgt: 0, aw_lat: 0, w_lat: 2, b_lat: 0, rdy_lat: 0, br: 2'b01, e_aw: 3, e_w: 5, e_b: 6, e_br: 2'b01};
        vt[6] = '{tgt: 4, aw_lat: 0, w_lat: 0, b_lat: 0, rdy_lat: 3, br: 2'b10, e_aw: 3, e_w: 3, e_b: 7, e_br: 2'b11};

        for (int k = 0; k < N; k++) begin
            aw_cnt[k] = 0; w_cnt[k] = 0; exp_aw_cnt[k] = 0; exp_w_cnt[k] = 0;
        end
        m_awaddr = '0; m_awprot = '0; m_awvalid = 1'b0;
        m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
        s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
        set_cfg(N, 0, 0, 0, 2'b00);

        repeat (3) @(negedge aclk);
        #2;
        chk("rst_master", {m_awready, m_wready, m_bvalid, m_bresp}, 0);
        chk("rst_slave", {s_awvalid, s_wvalid, s_bready}, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // AW alone must not start a transaction.
        #1;
        set_cfg(1, 0, 0, 0, 2'b00);
        hits = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            m_awvalid = 1'b1;
            #2;
            if (m_awready || m_wready || (|s_awvalid) || (|s_wvalid)) hits++;
        end
        chk("aw_only_idle", hits, 0);
        @(negedge aclk);
        m_awvalid = 1'b0;
        @(negedge aclk);

        for (int i = 0; i < 7; i++) begin
            a = 32'h1000_0000 * (i + 1) + 32'h40; p = 3'(i); d = 32'hA5A5_0000 + 32'(i); s = 4'(i + 9);
            if (vt[i].tgt < N) begin
                exp_aw_cnt[vt[i].tgt]++;
                exp_w_cnt[vt[i].tgt]++;
            end
            do_write(vt[i].tgt, vt[i].aw_lat, vt[i].w_lat, vt[i].b_lat, vt[i].rdy_lat, vt[i].br, a, p, d, s, r);
            judge($sformatf("vec%0d", i), vt[i].tgt, vt[i].e_aw, vt[i].e_w, vt[i].e_b, vt[i].e_br, r, a, p, d, s);
        end

        // Reset while forwarding: the write is dropped and the router idles.
        #1;
        set_cfg(2, 20, 20, 0, 2'b00);
        @(negedge aclk);
        m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        #2;
        chk("midfwd_awvalid", s_awvalid, 4'b0100);
        @(negedge aclk);
        aresetn = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #2;
        chk("midfwd_rst_master", {m_awready, m_wready, m_bvalid, m_bresp}, 0);
        chk("midfwd_rst_slave", {s_awvalid, s_wvalid, s_bready}, 0);
        a = 32'hDEAD_0010; p = 3'b101; d = 32'h1234_5678; s = 4'hF;
        model(1, 0, 0, 0, 0, 2'b01, e_aw, e_w, e_b, e_br);
        do_write(1, 0, 0, 0, 0, 2'b01, a, p, d, s, r);
        judge("post_rst", 1, e_aw, e_w, e_b, e_br, r, a, p, d, s);

        for (int i = 0; i < 40; i++) begin
            int t, awl, wl, bl, rl;
            logic [1:0] br;
            t = $urandom_range(0, N);
            awl = $urandom_range(0, 4); wl = $urandom_range(0, 4);
            bl = $urandom_range(0, 3);  rl = $urandom_range(0, 3);
            br = 2'($urandom_range(0, 3));
            a = $urandom; p = 3'($urandom_range(0, 7)); d = $urandom; s = 4'($urandom_range(0, 15));
            model(t, awl, wl, bl, rl, br, e_aw, e_w, e_b, e_br);
            do_write(t, awl, wl, bl, rl, br, a, p, d, s, r);
            judge($sformatf("rnd%0d", i), t, e_aw, e_w, e_b, e_br, r, a, p, d, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_router_wr.md
Name: axil_router_wr

Overview:
- Write-channel router stage that consumes the registered one-hot slave select (slv_valid) and decode-error flag (slv_invalid) from the write address decoder.
- Forwards one AXI-Lite write (AW + W) from the single upstream master to the selected slave, then returns that slave's B response.
- Unmapped addresses are terminated locally with DECERR; no slave is touched.
- One outstanding write at a time. Sits between the write arbiter output and the slave ports of the priority interconnect.

Parameters:
- NUMBER_SLAVE, 4, number of downstream slave ports.
- AXI_ADDR_WIDTH, 32, address width.
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- slv_valid  in  NUMBER_SLAVE  one-hot decoder select, valid one cycle after m_axil_awvalid && m_axil_wvalid.
- slv_invalid  in  1  decoder miss flag, same timing as slv_valid.
- m_axil_awaddr  in  AXI_ADDR_WIDTH  master write address.
- m_axil_awprot  in  3  master protection bits.
- m_axil_awvalid  in  1  master AW valid.
- m_axil_awready  out  1  AW ready to master.
- m_axil_wdata  in  AXI_DATA_WIDTH  master write data.
- m_axil_wstrb  in  AXI_DATA_WIDTH/8  master strobes.
- m_axil_wvalid  in  1  master W valid.
- m_axil_wready  out  1  W ready to master.
- m_axil_bresp  out  2  response to master.
- m_axil_bvalid  out  1  B valid to master.
- m_axil_bready  in  1  master B ready.
- s_axil_awaddr  out  NUMBER_SLAVE*AXI_ADDR_WIDTH  per-slave address, all slices equal to m_axil_awaddr.
- s_axil_awprot  out  NUMBER_SLAVE*3  per-slave prot, broadcast.
- s_axil_awvalid  out  NUMBER_SLAVE  per-slave AW valid.
- s_axil_awready  in  NUMBER_SLAVE  per-slave AW ready.
- s_axil_wdata  out  NUMBER_SLAVE*AXI_DATA_WIDTH  broadcast data.
- s_axil_wstrb  out  NUMBER_SLAVE*AXI_DATA_WIDTH/8  broadcast strobes.
- s_axil_wvalid  out  NUMBER_SLAVE  per-slave W valid.
- s_axil_wready  in  NUMBER_SLAVE  per-slave W ready.
- s_axil_bresp  in  NUMBER_SLAVE*2  per-slave response.
- s_axil_bvalid  in  NUMBER_SLAVE  per-slave B valid.
- s_axil_bready  out  NUMBER_SLAVE  per-slave B ready.

Behaviour:
- Reset: aresetn low at a rising aclk edge forces state IDLE and clears sel, aw_done, w_done.
  - All outputs derive from state/sel, so every valid/ready output is 0 and m_axil_bresp is 2'b00 while in reset.
  - Reset mid-transaction abandons the transaction with no response.
- FSM states: IDLE, DECODE, FWD, RESP, ERR_ACK, ERR_RESP.
- IDLE:
  - If m_axil_awvalid && m_axil_wvalid, go to DECODE.
  - AW or W alone does not start a transaction.
- DECODE (one cycle, the cycle the decoder output is valid):
  - Latch sel <= slv_valid.
  - If any bit of slv_valid is set, go to FWD.
  - Else if slv_invalid, go to ERR_ACK.
  - Else (master dropped valid, protocol violation) return to IDLE.
- FWD:
  - s_axil_awvalid[k] = sel[k] && !aw_done; s_axil_wvalid[k] = sel[k] && !w_done.
  - m_axil_awready = |(sel & s_axil_awready) && !aw_done; m_axil_wready is the same form using s_axil_wready and w_done.
  - aw_done/w_done set on their respective handshakes.
  - AW and W complete independently, in any order or in the same cycle.
  - When both are done (counting handshakes in the current cycle), go to RESP and clear both done flags.
- RESP:
  - m_axil_bvalid = |(sel & s_axil_bvalid).
  - m_axil_bresp = bresp slice of the selected slave.
  - s_axil_bready[k] = sel[k] && m_axil_bready.
  - On m_axil_bvalid && m_axil_bready, go to IDLE.
- ERR_ACK:
  - m_axil_awready = m_axil_wready = 1 for exactly one cycle, consuming the master's AW and W.
  - Go to ERR_RESP.
- ERR_RESP:
  - m_axil_bvalid = 1, m_axil_bresp = 2'b11 (DECERR).
  - Hold until m_axil_bready, then go to IDLE.
- Non-selected slaves see valid = 0 and bready = 0 at all times. Slave B signals outside RESP are ignored.
- Latency: earliest m_axil_awready is the 3rd cycle after valids rise (IDLE, DECODE, FWD).
- Back-to-back: a new write may begin in the IDLE cycle immediately after the B handshake.

Test Plan:
- Mapped write: awaddr maps to slave 1; slave 1 readies both channels in the first FWD cycle and returns bresp 2'b00 with bvalid two cycles later -> only s_axil_awvalid[1] and s_axil_wvalid[1] asserted; m_axil_bresp 2'b00; no other slave valid ever high.
- Unmapped address: slv_invalid=1 -> m_axil_awready and m_axil_wready high for one cycle, then m_axil_bvalid with bresp 2'b11; all s_axil_*valid stay 0.
- Split channels: slave 2 accepts W 3 cycles before AW -> s_axil_wvalid[2] drops after the W handshake, AW stays asserted until accepted; exactly one RESP entry.
- B backpressure: m_axil_bready held low 5 cycles with slave 0 bvalid high and bresp 2'b10 -> m_axil_bvalid stays high with bresp 2'b10 for all 5 cycles; s_axil_bready[0] rises only with bready.
- Reset mid-FWD: aresetn low for one cycle while in FWD -> next cycle all valid/ready outputs are 0 and state is IDLE.
- Back-to-back writes to slaves 3 then 0 -> second DECODE latches sel=4'b0001, and slave 3 receives no second valid.
